// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional trailing checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam logic [7:0] SYNC_BYTE      = 8'hA5;
   localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link plus instruction-memory write port and CPU control of the loader.
// The master modport is the loader side; slave is the host/memory/CPU side.
interface imem_loader_if #(
   parameter int ADDR_W = 8
);

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic              done;
   logic              error;

   modport master (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata,
      output cpu_reset,
      output done,
      output error
   );

   modport slave (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata,
      input  cpu_reset,
      input  done,
      input  error
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words; word_valid flags the byte that
// completes a word, with the full word presented on the same cycle.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        load,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  cnt_q;
   logic [23:0] shift_q;

   // The fourth byte completes the word straight from the input, so only the
   // three earlier bytes need storage.
   assign word       = {byte_in, shift_q};
   assign word_valid = load && (cnt_q == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else if (clear) begin
         cnt_q   <= '0;
      end else if (load) begin
         cnt_q   <= cnt_q + 2'd1;
         shift_q <= {byte_in, shift_q[23:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses A5/len/words frames into instruction-memory writes and
// releases the CPU once a full image lands. Checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.master bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        left_q, left_d;

   logic              rx_ready_q;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [31:0]       wdata_q;
   logic              cpu_reset_q;
   logic              done_q;
   logic              error_q;

   logic              accept;
   logic              asm_clear;
   logic              asm_load;
   logic              word_valid;
   logic [31:0]       word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   assign accept   = bus.rx_valid && rx_ready_q;
   assign asm_load = accept && (state_q == DATA);

   word_assembler u_word_assembler (
      .clk        (clk),
      .rst_n      (reset),
      .clear      (asm_clear),
      .load       (asm_load),
      .byte_in    (bus.rx_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      // NOTE: every signal gets its default first, so no path through the case infers a latch.
      state_d   = state_q;
      addr_d    = addr_q;
      left_d    = left_q;
      we_d      = 1'b0;
      asm_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      if (accept) begin
         unique case (state_q)
            IDLE, DONE, ERR: begin
               if (bus.rx_data == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
               if (bus.rx_data == 8'd0 || {24'd0, bus.rx_data} > DEPTH) begin
                  state_d = ERR;
               end else begin
                  state_d   = DATA;
                  addr_d    = '0;
                  left_d    = bus.rx_data;
                  asm_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_d    = '0;
`endif
               end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.rx_data;
`endif
               if (word_valid) begin
                  we_d   = 1'b1;
                  addr_d = addr_q + 1'b1;
                  left_d = left_q - 8'd1;
                  if (left_q == 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d = CSUM;
`else
                     state_d = DONE;
`endif
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               state_d = (bus.rx_data == csum_q) ? DONE : ERR;
            end
`endif
            default: ;
         endcase
      end
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         left_q      <= '0;
         rx_ready_q  <= 1'b0;
         we_q        <= 1'b0;
         imem_addr_q <= '0;
         wdata_q     <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge values.
         state_q     <= state_d;
         addr_q      <= addr_d;
         left_q      <= left_d;
         rx_ready_q  <= !we_d;
         we_q        <= we_d;
         if (we_d) begin
            imem_addr_q <= addr_q;
            wdata_q     <= word;
         end
         cpu_reset_q <= (state_d != DONE);
         done_q      <= (state_d == DONE);
         error_q     <= (state_d == ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.rx_ready   = rx_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.cpu_reset  = cpu_reset_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built at frame level, expected
// writes are queued per frame and a negedge monitor compares every write strobe.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   wr_t         exp_q[$];
   logic [31:0] words[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          armed    = 1'b0;
   bit          exp_done = 1'b0;
   bit          exp_err  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, ".done"},      bus.done,      exp_done);
      check({tag, ".error"},     bus.error,     exp_err);
      check({tag, ".cpu_reset"}, bus.cpu_reset, !exp_done);
   endtask

   // Offers one byte, with an occasional idle gap, and returns #1 after it transfers.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      if ($urandom_range(0, 3) == 0) begin
         bus.rx_valid = 1'b0;
         repeat ($urandom_range(1, 2)) @(posedge clk);
         #1;
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      forever begin
         @(negedge clk);
         if (bus.rx_ready) break;
         waited++;
         if (waited > 8) begin
            check("rx_ready_timeout", bus.rx_ready, 1);
            bus.rx_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_junk(input int k);
      logic [7:0] b;
      for (int i = 0; i < k; i++) begin
         do b = 8'($urandom); while (b == SYNC_BYTE);
         send_byte(b);
      end
      check_status("junk");
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   // Sends one frame from `words`; the outcome follows from length and checksum alone.
   task automatic send_frame(input int n, input bit bad_csum);
      logic [7:0] csum = 8'h00;
      logic [7:0] b;
      bit         len_ok = (n > 0) && (n <= DEPTH);
      if (len_ok)
         for (int i = 0; i < n; i++) exp_q.push_back('{addr: ADDR_W'(i), data: words[i]});
      send_byte(SYNC_BYTE);
      check("sync.cpu_reset", bus.cpu_reset, 1);
      check("sync.done",      bus.done,      0);
      check("sync.error",     bus.error,     0);
      send_byte(8'(n));
      if (!len_ok) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
      end else begin
         for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
               b    = words[i][8*k +: 8];
               csum = csum ^ b;
               send_byte(b);
               check("we_after_byte", bus.imem_we, (k == 3));
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         send_byte(bad_csum ? csum + 8'd1 : csum);
         exp_done = !bad_csum;
         exp_err  = bad_csum;
`else
         exp_done = 1'b1;
         exp_err  = 1'b0;
`endif
      end
      check_status("frame_end");
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (armed) check("rx_ready_vs_we", bus.rx_ready, !bus.imem_we);
      if (reset && bus.imem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", bus.imem_we, 0);
         end else begin
            e = exp_q.pop_front();
            check("imem_addr",  bus.imem_addr,  e.addr);
            check("imem_wdata", bus.imem_wdata, e.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      reset        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.cpu_reset",  bus.cpu_reset,  1);
      check("rst.rx_ready",   bus.rx_ready,   0);
      check("rst.imem_we",    bus.imem_we,    0);
      check("rst.done",       bus.done,       0);
      check("rst.error",      bus.error,      0);
      check("rst.imem_addr",  bus.imem_addr,  0);
      check("rst.imem_wdata", bus.imem_wdata, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel.rx_ready_low", bus.rx_ready, 0);
      @(posedge clk);
      #1;
      check("rel.rx_ready_high", bus.rx_ready, 1);
      armed = 1'b1;

      send_junk(3);

      words.delete();
      words.push_back(32'h12345678);
      send_frame(1, 1'b0);
      send_junk(2);

      words.delete();
      words.push_back(32'hCAFEF00D);
      send_frame(1, 1'b0);

      rand_words(3);
      send_frame(3, 1'b0);

      send_frame(0, 1'b0);
      send_junk(2);
      send_frame(DEPTH + 1, 1'b0);

      rand_words(2);
      send_frame(2, 1'b1);
      rand_words(2);
      send_frame(2, 1'b0);

      rand_words(DEPTH);
      send_frame(DEPTH, 1'b0);

      for (int f = 0; f < 10; f++) begin
         int n = $urandom_range(0, DEPTH + 2);
         rand_words(n);
         send_frame(n, ($urandom_range(0, 3) == 0));
         send_junk($urandom_range(0, 2));
      end

      send_byte(SYNC_BYTE);
      send_byte(8'd4);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clk);
      armed = 1'b0;
      reset = 1'b0;
      #1;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      check_status("midrst");
      check("midrst.rx_ready", bus.rx_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      armed = 1'b1;
      rand_words(2);
      send_frame(2, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("writes_outstanding", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
